// File: rtl/vdp_lite_pkg.sv
// Shared constants for the character fetch path: ROM geometry, fetch FSM
// encoding and the character ROM address helper.
package vdp_lite_pkg;

    localparam int CHAR_ADDR_BITS = 10;
    localparam int PIXELS_PER_ROW = 8;
    localparam int BPP            = 4;
    localparam int ROW_BITS       = PIXELS_PER_ROW * BPP;
    localparam int CHAR_IDX_BITS  = CHAR_ADDR_BITS - 4;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_ADDR1 = 2'd1;
    localparam logic [1:0] ENC_CAP0  = 2'd2;
    localparam logic [1:0] ENC_CAP1  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_ADDR1 = ENC_ADDR1,
        ST_CAP0  = ENC_CAP0,
        ST_CAP1  = ENC_CAP1
    } fetch_state_t;

    // {char, row, half}: half 0 holds pixels 0-3, half 1 holds pixels 4-7
    function automatic logic [CHAR_ADDR_BITS-1:0] char_rom_addr(
        input logic [CHAR_IDX_BITS-1:0] chr,
        input logic [2:0]               row,
        input logic                     half
    );
        return {chr, row, half};
    endfunction

endpackage

// File: rtl/char_row_shifter.sv
// Staging row plus shifting row for the character fetcher. The staging row
// takes a freshly fetched row; the shift row streams it out one pixel per
// accepted handshake. Optional horizontal flip under CHAR_ROW_FETCHER_HFLIP_EN.
module char_row_shifter
    import vdp_lite_pkg::*;
#(
    parameter int PAL_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stage_write,
    input  logic [ROW_BITS-1:0]     stage_row,
    input  logic [PAL_BITS-1:0]     stage_palette,
`ifdef CHAR_ROW_FETCHER_HFLIP_EN
    input  logic                    stage_flip,
`endif
    output logic                    stage_full,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [PAL_BITS+BPP-1:0] pix_data
);

    logic [ROW_BITS-1:0] stg_row;
    logic [ROW_BITS-1:0] sh_row;
    logic [PAL_BITS-1:0] stg_pal;
    logic [PAL_BITS-1:0] sh_pal;
    logic [2:0]          pix_count;
    logic [2:0]          pix_index;
    logic                row_full;
    logic                pix_fire;
    logic                row_done;
    logic                row_load;
`ifdef CHAR_ROW_FETCHER_HFLIP_EN
    logic                stg_flip;
    logic                sh_flip;
`endif

    assign pix_fire = row_full && pix_ready;
    assign row_done = pix_fire && (pix_count == 3'd7);
    // Reloading on the last pixel's handshake is what keeps back-to-back rows gapless
    assign row_load = stage_full && (!row_full || row_done);

    // Staging row: filled by the fetch FSM, freed when the shift row takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_full <= 1'b0;
            stg_row    <= '0;
            stg_pal    <= '0;
`ifdef CHAR_ROW_FETCHER_HFLIP_EN
            stg_flip   <= 1'b0;
`endif
        end else if (stage_write) begin
            stage_full <= 1'b1;
            stg_row    <= stage_row;
            stg_pal    <= stage_palette;
`ifdef CHAR_ROW_FETCHER_HFLIP_EN
            stg_flip   <= stage_flip;
`endif
        end else if (row_load) begin
            stage_full <= 1'b0;
        end
    end

    // Shift row: load from staging, then advance the pixel counter per handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            row_full  <= 1'b0;
            sh_row    <= '0;
            sh_pal    <= '0;
            pix_count <= '0;
`ifdef CHAR_ROW_FETCHER_HFLIP_EN
            sh_flip   <= 1'b0;
`endif
        end else if (row_load) begin
            row_full  <= 1'b1;
            sh_row    <= stg_row;
            sh_pal    <= stg_pal;
            pix_count <= '0;
`ifdef CHAR_ROW_FETCHER_HFLIP_EN
            sh_flip   <= stg_flip;
`endif
        end else if (pix_fire) begin
            pix_count <= pix_count + 3'd1;
            if (pix_count == 3'd7) begin
                row_full <= 1'b0;
            end
        end
    end

`ifdef CHAR_ROW_FETCHER_HFLIP_EN
    // A flipped row walks the nibbles from the top of word1 downwards
    assign pix_index = sh_flip ? ~pix_count : pix_count;
`else
    assign pix_index = pix_count;
`endif

    assign pix_valid = row_full;
    assign pix_data  = row_full ? {sh_pal, sh_row[int'(pix_index) * BPP +: BPP]} : '0;

endmodule

// File: rtl/char_row_fetcher.sv
// Character row fetcher: accepts tile requests, issues two character ROM
// reads per row and hands the assembled row to char_row_shifter.
// Optional horizontal flip is built when CHAR_ROW_FETCHER_HFLIP_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for a request; rom_address holds addr0 once accepted
//   ADDR1 | ROM sampling addr0; present addr1
//   CAP0  | word0 on rom_read_data; capture it
//   CAP1  | word1 on rom_read_data; write row into staging
module char_row_fetcher
    import vdp_lite_pkg::*;
#(
    parameter int CHAR_BITS = 6,
    parameter int PAL_BITS  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CHAR_BITS-1:0]      req_char,
    input  logic [2:0]                req_row,
    input  logic [PAL_BITS-1:0]       req_palette,
    input  logic                      req_hflip,
    output logic [CHAR_ADDR_BITS-1:0] rom_address,
    input  logic [15:0]               rom_read_data,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [PAL_BITS+3:0]       pix_data,
    output logic                      busy
);

    fetch_state_t         state;
    fetch_state_t         state_next;
    logic                 req_fire;
    logic                 stage_write;
    logic                 stage_full;
    logic [CHAR_BITS-1:0] lat_char;
    logic [2:0]           lat_row;
    logic [PAL_BITS-1:0]  lat_pal;
    logic [15:0]          word0;
`ifdef CHAR_ROW_FETCHER_HFLIP_EN
    logic                 lat_flip;
`else
    logic                 unused_hflip;
    assign unused_hflip = req_hflip;
`endif

    // Ready depends only on registered state, never on pix_ready or req_valid
    assign req_ready = (state == ST_IDLE) && !stage_full;
    assign req_fire  = req_valid && req_ready;
    assign busy      = (state != ST_IDLE) || stage_full || pix_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the staging write strobe
    always_comb begin
        state_next  = state;
        stage_write = 1'b0;
        case (state)
            ST_IDLE:  if (req_fire) state_next = ST_ADDR1;
            ST_ADDR1: state_next = ST_CAP0;
            ST_CAP0:  state_next = ST_CAP1;
            ST_CAP1: begin
                stage_write = 1'b1;
                state_next  = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Request latch, ROM address register and first-word capture
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_address <= '0;
            lat_char    <= '0;
            lat_row     <= '0;
            lat_pal     <= '0;
            word0       <= '0;
`ifdef CHAR_ROW_FETCHER_HFLIP_EN
            lat_flip    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        lat_char    <= req_char;
                        lat_row     <= req_row;
                        lat_pal     <= req_palette;
                        rom_address <= char_rom_addr(req_char, req_row, 1'b0);
`ifdef CHAR_ROW_FETCHER_HFLIP_EN
                        lat_flip    <= req_hflip;
`endif
                    end
                end
                ST_ADDR1: rom_address <= char_rom_addr(lat_char, lat_row, 1'b1);
                ST_CAP0:  word0 <= rom_read_data;
                default: begin
                end
            endcase
        end
    end

    char_row_shifter #(
        .PAL_BITS(PAL_BITS)
    ) u_shifter (
        .clk           (clk),
        .reset         (reset),
        .stage_write   (stage_write),
        .stage_row     ({rom_read_data, word0}),
        .stage_palette (lat_pal),
`ifdef CHAR_ROW_FETCHER_HFLIP_EN
        .stage_flip    (lat_flip),
`endif
        .stage_full    (stage_full),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data)
    );

endmodule

// File: tb/tb_char_row_fetcher.sv
// Bench for char_row_fetcher: behavioural ROM plus a row-level reference
// model that turns each accepted request into its eight expected pixels.
module tb_char_row_fetcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_char = '0;
    logic [2:0]  req_row = '0;
    logic [3:0]  req_palette = '0;
    logic        req_hflip = 1'b0;
    logic [9:0]  rom_address;
    logic [15:0] rom_read_data = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [7:0]  pix_data;
    logic        busy;

`ifdef CHAR_ROW_FETCHER_HFLIP_EN
    localparam bit FLIP_BUILT = 1'b1;
`else
    localparam bit FLIP_BUILT = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [15:0] rom [0:1023];
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    int          obs_cyc_q[$];
    int          hs_q[$];
    logic [16:0] stall_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    char_row_fetcher #(.CHAR_BITS(6), .PAL_BITS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_char     (req_char),
        .req_row      (req_row),
        .req_palette  (req_palette),
        .req_hflip    (req_hflip),
        .rom_address  (rom_address),
        .rom_read_data(rom_read_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Synchronous ROM: address sampled on the edge, data valid the following cycle
    always @(posedge clk) rom_read_data <= rom[rom_address];

    function automatic logic [7:0] ref_pixel(input logic [15:0] w0, input logic [15:0] w1,
                                             input logic [3:0] pal, input int n);
        logic [31:0] row;
        row = {w1, w0};
        return {pal, 4'((row >> (4 * n)) & 32'hF)};
    endfunction

    function automatic void model_accept(input logic [5:0] chr, input logic [2:0] row,
                                         input logic [3:0] pal, input logic flip);
        logic [15:0] w0;
        logic [15:0] w1;
        int src;
        w0 = rom[{chr, row, 1'b0}];
        w1 = rom[{chr, row, 1'b1}];
        for (int n = 0; n < 8; n++) begin
            src = (flip && FLIP_BUILT) ? 7 - n : n;
            exp_q.push_back(ref_pixel(w0, w1, pal, src));
        end
    endfunction

    // Observe handshakes (inputs stable at negedge are what the next posedge samples)
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_stall <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                model_accept(req_char, req_row, req_palette, req_hflip);
                hs_q.push_back(cyc);
            end
            if (pix_valid && pix_ready) begin
                obs_q.push_back(pix_data);
                obs_cyc_q.push_back(cyc);
            end
            if (prev_stall) stall_q.push_back({prev_data, pix_valid, pix_data});
            prev_stall <= pix_valid && !pix_ready;
            prev_data  <= pix_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        hs_q.delete();
        stall_q.delete();
    endtask

    task automatic rand_fields();
        req_char    = 6'($urandom_range(0, 63));
        req_row     = 3'($urandom_range(0, 7));
        req_palette = 4'($urandom_range(0, 15));
        req_hflip   = 1'($urandom_range(0, 1));
    endtask

    task automatic issue_one(input logic [5:0] chr, input logic [2:0] row, input logic [3:0] pal,
                             input logic flip, output int hs, output bit ok);
        req_char = chr; req_row = row; req_palette = pal; req_hflip = flip;
        req_valid = 1'b1;
        ok = 1'b0;
        hs = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                hs = cyc;
                break;
            end
            tick();
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    // mode 0: pix_ready high, 1: toggles every cycle, 2: random
    task automatic run_stream(input int n_req, input int mode, input int budget, output bit ok);
        int k;
        bit hs;
        k = 0;
        ok = 1'b0;
        pix_ready = 1'b1;
        rand_fields();
        req_valid = 1'b1;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            hs = req_valid && req_ready;
            if (hs) k++;
            if (k == n_req && !req_valid && obs_q.size() >= 8 * n_req) begin
                ok = 1'b1;
                break;
            end
            tick();
            if (hs) begin
                if (k < n_req) rand_fields();
                else req_valid = 1'b0;
            end
            case (mode)
                1:       pix_ready = ~pix_ready;
                2:       pix_ready = ($urandom_range(0, 3) != 0);
                default: pix_ready = 1'b1;
            endcase
        end
        req_valid = 1'b0;
        pix_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        pix_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
        n_checks++; if (rom_address !== 10'h000) begin n_fail++; $display("FAIL reset_rom_address: got %h expected 000", rom_address); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (pix_data !== 8'h00) begin n_fail++; $display("FAIL reset_pix_data: got %h expected 00", pix_data); end
        tick();
    endtask

    task automatic test_basic();
        int hs;
        bit ok;
        clear_sb();
        rom[10'h056] = 16'h3210;
        rom[10'h057] = 16'h7654;
        pix_ready = 1'b1;
        issue_one(6'd5, 3'd3, 4'hA, 1'b0, hs, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_accept: got ready=0 expected 1"); end
        @(negedge clk);
        n_checks++; if (rom_address !== 10'h056) begin n_fail++; $display("FAIL basic_addr0: got %h expected 056", rom_address); end
        @(negedge clk);
        n_checks++; if (rom_address !== 10'h057) begin n_fail++; $display("FAIL basic_addr1: got %h expected 057", rom_address); end
        tick();
        wait_obs(8, 40, ok);
        n_checks++; if (!ok || obs_q.size() != 8) begin n_fail++; $display("FAIL basic_count: got %0d pixels expected 8", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL basic_pixel%0d: got %h expected %h", i, obs_q[i], 8'(8'hA0 + i)); end
        end
        // Request present in cycle hs -> edge E0 = hs+1; shift row loads at E0+4, first valid cycle index hs+5
        if (ok) begin
            n_checks++; if (obs_cyc_q[0] != hs + 5) begin n_fail++; $display("FAIL basic_latency: got cycle %0d expected %0d", obs_cyc_q[0], hs + 5); end
            n_checks++; if (obs_cyc_q[7] != hs + 12) begin n_fail++; $display("FAIL basic_contiguous: got cycle %0d expected %0d", obs_cyc_q[7], hs + 12); end
        end
    endtask

    task automatic test_hflip();
        int hs;
        bit ok;
        logic [7:0] want;
        clear_sb();
        issue_one(6'd5, 3'd3, 4'hA, 1'b1, hs, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL hflip_accept: got ready=0 expected 1"); end
        wait_obs(8, 40, ok);
        n_checks++; if (!ok || obs_q.size() != 8) begin n_fail++; $display("FAIL hflip_count: got %0d pixels expected 8", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            want = FLIP_BUILT ? 8'(8'hA7 - i) : 8'(8'hA0 + i);
            n_checks++;
            if (obs_q[i] !== want) begin n_fail++; $display("FAIL hflip_pixel%0d: got %h expected %h", i, obs_q[i], want); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_sb();
        run_stream(4, 0, 200, ok);
        n_checks++; if (!ok || obs_q.size() != 32) begin n_fail++; $display("FAIL b2b_count: got %0d pixels expected 32", obs_q.size()); end
        n_checks++; if (exp_q.size() != 32) begin n_fail++; $display("FAIL b2b_accepts: got %0d model pixels expected 32", exp_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_pixel%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() == 32 && hs_q.size() == 4) begin
            n_checks++; if (obs_cyc_q[31] - obs_cyc_q[0] != 31) begin n_fail++; $display("FAIL b2b_gapless: got span %0d expected 31", obs_cyc_q[31] - obs_cyc_q[0]); end
            // Staging frees at E0+4 for the first row, then only as each row's last pixel drains
            n_checks++; if (hs_q[1] - hs_q[0] != 5) begin n_fail++; $display("FAIL b2b_gap1: got %0d expected 5", hs_q[1] - hs_q[0]); end
            n_checks++; if (hs_q[2] - hs_q[1] != 8) begin n_fail++; $display("FAIL b2b_gap2: got %0d expected 8", hs_q[2] - hs_q[1]); end
            n_checks++; if (hs_q[3] - hs_q[2] != 8) begin n_fail++; $display("FAIL b2b_gap3: got %0d expected 8", hs_q[3] - hs_q[2]); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        clear_sb();
        run_stream(2, 1, 200, ok);
        n_checks++; if (!ok || obs_q.size() != 16) begin n_fail++; $display("FAIL stall_count: got %0d pixels expected 16", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_pixel%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (stall_q.size() == 0) begin n_fail++; $display("FAIL stall_seen: got 0 stalls expected >0"); end
        for (int i = 0; i < stall_q.size(); i++) begin
            n_checks++;
            if (stall_q[i][8] !== 1'b1 || stall_q[i][7:0] !== stall_q[i][16:9]) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, stall_q[i][8], stall_q[i][7:0], stall_q[i][16:9]);
            end
        end
    endtask

    task automatic test_bubble();
        int hs_a;
        int hs_b;
        int gap;
        bit ok;
        clear_sb();
        pix_ready = 1'b1;
        issue_one(6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0, hs_a, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bubble_accept_a: got ready=0 expected 1"); end
        // Row B's E3 lands on the edge where row A's pixel 7 is accepted
        while (cyc < hs_a + 9) tick();
        issue_one(6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b1, hs_b, ok);
        n_checks++; if (!ok || hs_b != hs_a + 9) begin n_fail++; $display("FAIL bubble_accept_b: got cycle %0d expected %0d", hs_b, hs_a + 9); end
        wait_obs(16, 60, ok);
        n_checks++; if (!ok || obs_q.size() != 16) begin n_fail++; $display("FAIL bubble_count: got %0d pixels expected 16", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bubble_pixel%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() == 16) begin
            n_checks++; if (obs_cyc_q[7] != hs_a + 12) begin n_fail++; $display("FAIL bubble_a_end: got cycle %0d expected %0d", obs_cyc_q[7], hs_a + 12); end
            gap = obs_cyc_q[8] - obs_cyc_q[7];
            n_checks++; if (gap < 1 || gap > 2) begin n_fail++; $display("FAIL bubble_gap: got %0d expected 1..2", gap); end
            n_checks++; if (obs_cyc_q[15] - obs_cyc_q[8] != 7) begin n_fail++; $display("FAIL bubble_b_contig: got span %0d expected 7", obs_cyc_q[15] - obs_cyc_q[8]); end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int hs;
        bit ok;
        clear_sb();
        pix_ready = 1'b1;
        rom[{6'd9, 3'd1, 1'b0}] = 16'hBEEF;
        rom[{6'd9, 3'd1, 1'b1}] = 16'hCAFE;
        issue_one(6'd9, 3'd1, 4'h3, 1'b0, hs, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_accept: got ready=0 expected 1"); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_pix_valid: got %b expected 0", pix_valid); end
        n_checks++; if (rom_address !== 10'h000) begin n_fail++; $display("FAIL midrst_rom_address: got %h expected 000", rom_address); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        tick();
        repeat (6) tick();
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_discard: got %0d pixels expected 0", obs_q.size()); end
        clear_sb();
        rom[{6'd9, 3'd1, 1'b0}] = 16'h1357;
        rom[{6'd9, 3'd1, 1'b1}] = 16'h9BDF;
        issue_one(6'd9, 3'd1, 4'h6, 1'b0, hs, ok);
        wait_obs(8, 40, ok);
        n_checks++; if (!ok || obs_q.size() != 8) begin n_fail++; $display("FAIL midrst_count: got %0d pixels expected 8", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_pixel%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit ok;
        clear_sb();
        run_stream(6, 2, 800, ok);
        n_checks++; if (!ok || obs_q.size() != 48) begin n_fail++; $display("FAIL random_count: got %0d pixels expected 48", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_pixel%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) rom[a] = 16'($urandom);
        test_reset();
        test_basic();
        test_hflip();
        test_back_to_back();
        test_stall();
        test_bubble();
        test_reset_mid_fetch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
